// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and the 4-bit operation codes.
// The control unit imports this package as well, so both sides use the same encodings.
package alu_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ShamtW = 6;

  typedef enum logic [3:0] {
    AluAnd  = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluXor  = 4'b0011,
    AluSub  = 4'b0110,
    AluSlt  = 4'b0111,
    AluSltu = 4'b1000,
    AluSll  = 4'b1001,
    AluSrl  = 4'b1010,
    AluSra  = 4'b1011,
    AluNor  = 4'b1100
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL/SRA. Only the low six bits of the shift amount are used.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]   a_i,
  input  logic [ShamtW-1:0] shamt_i,
  input  alu_op_e           op_i,
  output logic [XLEN-1:0]   res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      AluSll:  res_o = a_i << shamt_i;
      AluSrl:  res_o = a_i >> shamt_i;
      AluSra:  res_o = $unsigned($signed(a_i) >>> shamt_i);
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 64-bit RV64 integer ALU: combinational result/zero/overflow plus a registered copy
// of result and zero for multicycle or pipelined consumers.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      control,
  output logic            zero,
  output logic [XLEN-1:0] res,
  output logic            ovf,
  output logic [XLEN-1:0] res_q,
  output logic            zero_q
);

  localparam int unsigned Msb = XLEN - 1;

  alu_op_e         op;
  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] shift_res;
  logic            slt;
  logic            sltu;

  assign op   = alu_op_e'(control);
  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);
  assign sltu = a < b;

  alu_shifter u_shifter (
    .a_i    (a),
    .shamt_i(b[ShamtW-1:0]),
    .op_i   (op),
    .res_o  (shift_res)
  );

  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      AluAnd:  res = a & b;
      AluOr:   res = a | b;
      AluXor:  res = a ^ b;
      AluNor:  res = ~(a | b);
      AluAdd: begin
        res = sum;
        ovf = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
      end
      AluSub: begin
        res = diff;
        ovf = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
      end
      AluSlt:  res = {{(XLEN-1){1'b0}}, slt};
      AluSltu: res = {{(XLEN-1){1'b0}}, sltu};
      AluSll, AluSrl, AluSra: res = shift_res;
      default: res = '0;
    endcase
  end

  assign zero = (res == '0);

  // Reset value keeps zero_q consistent with res_q == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      res_q  <= res;
      zero_q <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: scoreboard queues of expected combinational and
// registered results, compared when the DUT output is sampled.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic        zero;
    logic        ovf;
  } comb_exp_t;

  typedef struct {
    string       tag;
    logic [63:0] res_q;
    logic        zero_q;
  } reg_exp_t;

  logic        clk;
  logic        reset;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  control;
  logic        zero;
  logic [63:0] res;
  logic        ovf;
  logic [63:0] res_q;
  logic        zero_q;

  comb_exp_t comb_sb[$];
  reg_exp_t  reg_sb[$];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [63:0] MaxPos = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;
  localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

  alu u_dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .control(control),
    .zero   (zero),
    .res    (res),
    .ovf    (ovf),
    .res_q  (res_q),
    .zero_q (zero_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one combinational vector, queue its expectation, then sample and compare.
  task automatic comb_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                         input logic [3:0] ctrl, input logic [63:0] er, input logic ez,
                         input logic eo);
    comb_exp_t e;
    a       = av;
    b       = bv;
    control = ctrl;
    comb_sb.push_back('{tag: tag, res: er, zero: ez, ovf: eo});
    #1;
    e = comb_sb.pop_front();
    check_eq({e.tag, ".res"}, res, e.res);
    check_eq({e.tag, ".zero"}, {63'b0, zero}, {63'b0, e.zero});
    check_eq({e.tag, ".ovf"}, {63'b0, ovf}, {63'b0, e.ovf});
  endtask

  // Drive at negedge, expect the registered outputs just after the next rising edge.
  task automatic reg_op(input string tag, input logic rst, input logic [63:0] av,
                        input logic [63:0] bv, input logic [3:0] ctrl,
                        input logic [63:0] er_comb, input logic [63:0] erq, input logic ezq);
    reg_exp_t e;
    @(negedge clk);
    reset   = rst;
    a       = av;
    b       = bv;
    control = ctrl;
    reg_sb.push_back('{tag: tag, res_q: erq, zero_q: ezq});
    #1;
    check_eq({tag, ".comb_res"}, res, er_comb);
    @(posedge clk);
    #1;
    e = reg_sb.pop_front();
    check_eq({e.tag, ".res_q"}, res_q, e.res_q);
    check_eq({e.tag, ".zero_q"}, {63'b0, zero_q}, {63'b0, e.zero_q});
  endtask

  initial begin
    reset   = 1'b1;
    a       = '0;
    b       = '0;
    control = 4'b0000;

    // Registered path: reset, load, reset again, then further data.
    reg_op("reg_rst0", 1'b1, 64'd5, 64'd5, 4'b0010, 64'd10, 64'd0, 1'b1);
    reg_op("reg_add",  1'b0, 64'd1245, 64'd976, 4'b0010, 64'd2221, 64'd2221, 1'b0);
    reg_op("reg_rst1", 1'b1, 64'd1245, 64'd976, 4'b0010, 64'd2221, 64'd0, 1'b1);
    reg_op("reg_sub0", 1'b0, 64'd5, 64'd5, 4'b0110, 64'd0, 64'd0, 1'b1);
    reg_op("reg_add2", 1'b0, 64'd25, 64'd5, 4'b0010, 64'd30, 64'd30, 1'b0);

    @(negedge clk);
    reset = 1'b0;

    comb_op("sub_5_5",     64'd5, 64'd5, 4'b0110, 64'd0, 1'b1, 1'b0);
    comb_op("sub_0_5",     64'd0, 64'd5, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0);
    comb_op("sub_25_5",    64'd25, 64'd5, 4'b0110, 64'd20, 1'b0, 1'b0);
    comb_op("sub_1245",    64'd1245, 64'd976, 4'b0110, 64'd269, 1'b0, 1'b0);
    comb_op("sub_0_0",     64'd0, 64'd0, 4'b0110, 64'd0, 1'b1, 1'b0);
    comb_op("sub_min_1",   MinNeg, 64'd1, 4'b0110, MaxPos, 1'b0, 1'b1);
    comb_op("sub_m1_1",    AllOne, 64'd1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);

    comb_op("add_5_5",     64'd5, 64'd5, 4'b0010, 64'd10, 1'b0, 1'b0);
    comb_op("add_0_5",     64'd0, 64'd5, 4'b0010, 64'd5, 1'b0, 1'b0);
    comb_op("add_25_5",    64'd25, 64'd5, 4'b0010, 64'd30, 1'b0, 1'b0);
    comb_op("add_0_0",     64'd0, 64'd0, 4'b0010, 64'd0, 1'b1, 1'b0);
    comb_op("add_1245",    64'd1245, 64'd976, 4'b0010, 64'd2221, 1'b0, 1'b0);
    comb_op("add_max_1",   MaxPos, 64'd1, 4'b0010, MinNeg, 1'b0, 1'b1);
    comb_op("add_m1_1",    AllOne, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0);

    comb_op("and_5_5",     64'd5, 64'd5, 4'b0000, 64'd5, 1'b0, 1'b0);
    comb_op("and_0_5",     64'd0, 64'd5, 4'b0000, 64'd0, 1'b1, 1'b0);
    comb_op("and_25_5",    64'd25, 64'd5, 4'b0000, 64'd1, 1'b0, 1'b0);
    comb_op("and_1245",    64'd1245, 64'd976, 4'b0000, 64'd208, 1'b0, 1'b0);
    comb_op("and_max_no_ovf", MaxPos, 64'd1, 4'b0000, 64'd1, 1'b0, 1'b0);
    comb_op("or_5_5",      64'd5, 64'd5, 4'b0001, 64'd5, 1'b0, 1'b0);
    comb_op("or_25_5",     64'd25, 64'd5, 4'b0001, 64'd29, 1'b0, 1'b0);
    comb_op("or_0_0",      64'd0, 64'd0, 4'b0001, 64'd0, 1'b1, 1'b0);
    comb_op("or_1245",     64'd1245, 64'd976, 4'b0001, 64'd2013, 1'b0, 1'b0);
    comb_op("xor_1245",    64'd1245, 64'd976, 4'b0011, 64'd1805, 1'b0, 1'b0);
    comb_op("nor_0_0",     64'd0, 64'd0, 4'b1100, AllOne, 1'b0, 1'b0);
    comb_op("nor_1245",    64'd1245, 64'd976, 4'b1100, ~64'd2013, 1'b0, 1'b0);

    comb_op("slt_m1_1",    AllOne, 64'd1, 4'b0111, 64'd1, 1'b0, 1'b0);
    comb_op("sltu_m1_1",   AllOne, 64'd1, 4'b1000, 64'd0, 1'b1, 1'b0);
    comb_op("slt_1_m1",    64'd1, AllOne, 4'b0111, 64'd0, 1'b1, 1'b0);
    comb_op("sltu_1_m1",   64'd1, AllOne, 4'b1000, 64'd1, 1'b0, 1'b0);

    comb_op("sra_m8_1",    64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 4'b1011,
            64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0);
    comb_op("srl_m8_60",   64'hFFFF_FFFF_FFFF_FFF8, 64'd60, 4'b1010, 64'd15, 1'b0, 1'b0);
    comb_op("sll_1_64",    64'd1, 64'd64, 4'b1001, 64'd1, 1'b0, 1'b0);
    comb_op("sll_1_hi4",   64'd1, 64'h0000_0000_0000_0104, 4'b1001, 64'd16, 1'b0, 1'b0);
    comb_op("sra_min_0",   MinNeg, 64'd0, 4'b1011, MinNeg, 1'b0, 1'b0);
    comb_op("sra_min_63",  MinNeg, 64'd63, 4'b1011, AllOne, 1'b0, 1'b0);
    comb_op("sra_pos_4",   64'h0000_0000_0000_0F00, 64'd4, 4'b1011, 64'h0000_0000_0000_00F0,
            1'b0, 1'b0);

    comb_op("undef_1111",  64'd5, 64'd5, 4'b1111, 64'd0, 1'b1, 1'b0);
    comb_op("undef_0100",  MaxPos, 64'd1, 4'b0100, 64'd0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
